// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: A - B - Bin, one bit per clock LSB first, through a
// single full-subtractor cell with the borrow carried in a register.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Zero,
  output logic             Ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Full-subtractor cell: returns {borrow, sub}.
  function automatic logic [1:0] fs_cell(input logic a, input logic b, input logic c);
    logic d;
    logic bo;
    d  = a ^ b ^ c;
    bo = (~a & b) | (~(a ^ b) & c);
    return {bo, d};
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic             borrow_r;
  logic [CW-1:0]    cnt_r;
  logic [1:0]       cell_s;
  logic [WIDTH-1:0] res_nxt_s;
  logic             last_s;
  logic             accept_s;
  logic             finish_s;

  // Next-state logic plus the bit-slice evaluated this cycle.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    finish_s    = 1'b0;
    cell_s      = fs_cell(a_r[0], b_r[0], borrow_r);
    res_nxt_s   = {cell_s[0], res_r[WIDTH-1:1]};
    last_s      = (cnt_r == CW'(WIDTH - 1));
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_nxt_s = ST_DONE;
          finish_s    = 1'b1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand, borrow and partial-result shift registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      res_r    <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
      cnt_r    <= {CW{1'b0}};
    end else if (accept_s) begin
      a_r      <= A;
      b_r      <= B;
      borrow_r <= Bin;
      cnt_r    <= {CW{1'b0}};
    end else if (state_r == ST_RUN) begin
      a_r      <= {1'b0, a_r[WIDTH-1:1]};
      b_r      <= {1'b0, b_r[WIDTH-1:1]};
      res_r    <= res_nxt_s;
      borrow_r <= cell_s[1];
      cnt_r    <= cnt_r + CW'(1);
    end
  end

  // Result outputs change only when the MSB completes; Ovf compares borrow in/out of the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      Diff <= {WIDTH{1'b0}};
      Bout <= 1'b0;
      Zero <= 1'b0;
      Ovf  <= 1'b0;
    end else begin
      busy <= (state_nxt_s != ST_IDLE);
      done <= finish_s;
      if (finish_s) begin
        Diff <= res_nxt_s;
        Bout <= cell_s[1];
        Zero <= (res_nxt_s == {WIDTH{1'b0}});
        Ovf  <= borrow_r ^ cell_s[1];
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor (WIDTH=8) with hand-computed results.
module tb_serial_subtractor;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;
  logic             bin_s;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             ovf;

  int               n_vec = 0;
  int               n_err = 0;
  logic [WIDTH-1:0] last_diff = 8'h00;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .A    (a_s),
    .B    (b_s),
    .Bin  (bin_s),
    .busy (busy),
    .done (done),
    .Diff (diff),
    .Bout (bout),
    .Zero (zero),
    .Ovf  (ovf)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic bin, input logic [7:0] ed, input logic eb,
                        input logic ez, input logic eo, input bit mid, input bit hold);
    int done_k;
    int done_n;
    int busy_n;
    bit held;
    done_k = 0;
    done_n = 0;
    busy_n = 0;
    held   = 1'b1;
    a_s    = a;
    b_s    = b;
    bin_s  = bin;
    start  = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= WIDTH + 2; k++) begin
      @(negedge clk);
      if (!hold && k == 1) start = 1'b0;
      if (mid && k == 3) begin
        start = 1'b1;
        a_s   = 8'hFF;
        b_s   = 8'h00;
        bin_s = 1'b1;
      end
      if (mid && k == 4) start = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_k == 0) done_k = k;
      end
      if (done_k == 0 && diff !== last_diff) held = 1'b0;
    end
    check_val({tag, "_done_latency"}, done_k, WIDTH + 1);
    check_val({tag, "_done_pulses"}, done_n, 1);
    check_val({tag, "_busy_cycles"}, busy_n, WIDTH + 1);
    check_val({tag, "_diff_hold"}, {31'd0, held}, 32'd1);
    check_val({tag, "_diff"}, {24'd0, diff}, {24'd0, ed});
    check_val({tag, "_bout"}, {31'd0, bout}, {31'd0, eb});
    check_val({tag, "_zero"}, {31'd0, zero}, {31'd0, ez});
    check_val({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
    last_diff = ed;
  endtask

  initial begin
    bit saw_done;
    rst_n = 1'b0;
    start = 1'b0;
    a_s   = 8'h00;
    b_s   = 8'h00;
    bin_s = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset_outputs", {20'd0, busy, done, diff, bout, zero, ovf}, 32'd0);
    rst_n = 1'b1;

    run_op("basic",    8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("underflow",8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("ovf_neg",  8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("ovf_pos",  8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("zero_bin", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("mid_start",8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("hold_a",   8'h40, 8'h41, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op("hold_b",   8'hC8, 8'h64, 1'b0, 8'h64, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Abort an operation with reset while bit 4 is in flight.
    a_s   = 8'h12;
    b_s   = 8'h34;
    bin_s = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check_val("abort_busy_before", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_val("abort_outputs", {20'd0, busy, done, diff, bout, zero, ovf}, 32'd0);
    saw_done = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check_val("abort_no_done", {31'd0, saw_done}, 32'd0);
    rst_n     = 1'b1;
    last_diff = 8'h00;
    run_op("after_rst",8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
